// File: rtl/irq_ctrl8_pkg.sv
// Shared constants and FSM state type for the 8-channel interrupt controller.
package irq_ctrl8_pkg;
  localparam int N_CH  = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;
endpackage

// File: rtl/irq_ctrl8_prio_enc8.sv
// 8:3 priority encoder, bit 7 highest; valid flags any set input.
module prio_enc8
  import irq_ctrl8_pkg::*;
(
  input  logic [N_CH-1:0]  iIn,
  output logic [VEC_W-1:0] oIdx,
  output logic             oValid
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    oIdx   = '0;
    oValid = |iIn;
    for (int i = 0; i < N_CH; i++) begin
      if (iIn[i]) oIdx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl8.sv
// 8-channel interrupt controller: request capture, masking, fixed or rotating
// priority, and an IRQ/ACK/EOI handshake toward one shared service resource.
//
//  state | meaning
//  IDLE  | no grant issued; waiting for an eligible channel and iEI=0
//  REQ   | oIrq high, oVec presented, waiting for iAck
//  SERV  | resource servicing oVec, waiting for iEoi
module irq_ctrl8
  import irq_ctrl8_pkg::*;
#(
  parameter bit ROTATE = 1'b0,
  parameter bit EDGE   = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [N_CH-1:0]  iReq,
  input  logic [N_CH-1:0]  iMask,
  input  logic             iEI,
  input  logic             iAck,
  input  logic             iEoi,
  output logic             oIrq,
  output logic [VEC_W-1:0] oVec,
  output logic             oBusy,
  output logic [N_CH-1:0]  oPend,
  output logic             oEO
);

  state_t            state, stateNext;
  logic              irqNext, busyNext;
  logic [VEC_W-1:0]  vecNext;
  logic              ackTaken, eoiTaken;
  logic [N_CH-1:0]   pend, pendNext, reqPrev;
  logic [N_CH-1:0]   setMask, clrMask, eligible, rotEl;
  logic [2*N_CH-1:0] dblEl;
  logic [VEC_W-1:0]  lastSvc, rotShift, winIdx, winner;
  logic              winValid;

  assign eligible = pend & ~iMask;

  // Rotating mode: rotate so channel lastSvc-1 lands on bit 7, then undo it.
  assign rotShift = ROTATE ? lastSvc : '0;
  assign dblEl    = {eligible, eligible} >> rotShift;
  assign rotEl    = dblEl[N_CH-1:0];

  prio_enc8 uPrio (
    .iIn    (rotEl),
    .oIdx   (winIdx),
    .oValid (winValid)
  );

  assign winner = winIdx + rotShift;

  // Capture new requests; a set in the same cycle as the ack clear wins.
  assign setMask  = EDGE ? (~iReq & reqPrev) : ~iReq;
  assign clrMask  = ackTaken ? (N_CH'(1) << oVec) : '0;
  assign pendNext = (pend & ~clrMask) | setMask;

  // Next-state and registered-output decode.
  always_comb begin
    stateNext = state;
    irqNext   = oIrq;
    vecNext   = oVec;
    busyNext  = oBusy;
    ackTaken  = 1'b0;
    eoiTaken  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!iEI && winValid) begin
          stateNext = REQ;
          vecNext   = winner;
          irqNext   = 1'b1;
        end
      end
      REQ: begin
        if (iAck) begin
          stateNext = SERV;
          irqNext   = 1'b0;
          busyNext  = 1'b1;
          ackTaken  = 1'b1;
        end else if (iEI) begin
          stateNext = IDLE;
          irqNext   = 1'b0;
        end
      end
      SERV: begin
        if (iEoi) begin
          stateNext = IDLE;
          busyNext  = 1'b0;
          eoiTaken  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        irqNext   = 1'b0;
        busyNext  = 1'b0;
      end
    endcase
  end

  // State, handshake outputs, pending register and rotation pointer.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      oIrq    <= 1'b0;
      oVec    <= '0;
      oBusy   <= 1'b0;
      pend    <= '0;
      reqPrev <= '1;
      lastSvc <= '0;
    end else begin
      state   <= stateNext;
      oIrq    <= irqNext;
      oVec    <= vecNext;
      oBusy   <= busyNext;
      pend    <= pendNext;
      reqPrev <= iReq;
      if (eoiTaken) lastSvc <= oVec;
    end
  end

  assign oPend = pend;
  assign oEO   = ~iEI & ~|eligible;

endmodule

// File: tb/tb_irq_ctrl8.sv
module tb_irq_ctrl8;
  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iReq, iMask;
  logic       iEI, iAck, iEoi;
  logic       oIrq, oBusy, oEO;
  logic [2:0] oVec;
  logic [7:0] oPend;
  logic       oIrqR, oBusyR, oEOR;
  logic [2:0] oVecR;
  logic [7:0] oPendR;

  int errCnt = 0;
  int chkCnt = 0;
  logic [2:0] expQ[$];
  logic [2:0] expV;
  bit ok;

  always #5 iClk = ~iClk;

  irq_ctrl8 #(.ROTATE(1'b0), .EDGE(1'b1)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iMask(iMask), .iEI(iEI),
    .iAck(iAck), .iEoi(iEoi), .oIrq(oIrq), .oVec(oVec), .oBusy(oBusy),
    .oPend(oPend), .oEO(oEO));

  irq_ctrl8 #(.ROTATE(1'b1), .EDGE(1'b1)) dutR (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iMask(iMask), .iEI(iEI),
    .iAck(iAck), .iEoi(iEoi), .oIrq(oIrqR), .oVec(oVecR), .oBusy(oBusyR),
    .oPend(oPendR), .oEO(oEOR));

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iRst = 1'b1; iReq = 8'hFF; iMask = 8'h00; iEI = 1'b0; iAck = 1'b0; iEoi = 1'b0;
    expQ.delete();
    repeat (2) tick();
    iRst = 1'b0;
  endtask

  // Bounded wait for a grant on the selected instance.
  task automatic waitIrq(input bit rot, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((rot ? oIrqR : oIrq) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic popExp(output logic [2:0] v);
    chkCnt++;
    if (expQ.size() == 0) begin
      errCnt++;
      $display("FAIL scoreboard_empty got=%0d expected queued vector", oVec);
      v = 'x;
    end else v = expQ.pop_front();
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReq = 8'hFF; iMask = 8'h00; iEI = 1'b0; iAck = 1'b0; iEoi = 1'b0;
    tick();
    chkCnt++; if ({oIrq, oVec, oBusy, oPend} !== 13'h0) begin errCnt++;
      $display("FAIL reset_outputs got irq=%b vec=%0d busy=%b pend=%h expected all 0", oIrq, oVec, oBusy, oPend); end
    chkCnt++; if (oEO !== 1'b1 || oEOR !== 1'b1) begin errCnt++;
      $display("FAIL reset_eo got=%b/%b expected 1", oEO, oEOR); end
    doReset();
    iReq = 8'hFB;
    tick();
    iReq = 8'hFF;
    expQ.push_back(3'd2);
    chkCnt++; if (oPend !== 8'h04 || oIrq !== 1'b0) begin errCnt++;
      $display("FAIL lat_pend got pend=%h irq=%b expected 04/0", oPend, oIrq); end
    tick();
    chkCnt++; if (oIrq !== 1'b1) begin errCnt++;
      $display("FAIL lat_irq got=%b expected 1", oIrq); end
    popExp(expV);
    chkCnt++; if (oVec !== expV) begin errCnt++;
      $display("FAIL lat_vec got=%0d expected %0d", oVec, expV); end
    chkCnt++; if (oEO !== 1'b0) begin errCnt++;
      $display("FAIL lat_eo got=%b expected 0", oEO); end
  endtask

  task automatic test_back_to_back();
    doReset();
    iReq = 8'hBD;
    tick();
    iReq = 8'hFF;
    expQ.push_back(3'd6);
    expQ.push_back(3'd1);
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV) begin errCnt++;
      $display("FAIL fixed_prio got irq=%b vec=%0d expected 1/%0d", oIrq, oVec, expV); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chkCnt++; if (oBusy !== 1'b1 || oIrq !== 1'b0 || oPend !== 8'h02) begin errCnt++;
      $display("FAIL ack_serv got busy=%b irq=%b pend=%h expected 1/0/02", oBusy, oIrq, oPend); end
    iEoi = 1'b1;
    tick();
    iEoi = 1'b0;
    chkCnt++; if (oBusy !== 1'b0 || oIrq !== 1'b0) begin errCnt++;
      $display("FAIL eoi_idle got busy=%b irq=%b expected 0/0", oBusy, oIrq); end
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV || oPend !== 8'h02) begin errCnt++;
      $display("FAIL b2b_grant got irq=%b vec=%0d pend=%h expected 1/%0d/02", oIrq, oVec, oPend, expV); end
  endtask

  task automatic test_rotate();
    doReset();
    iReq = 8'hD7;
    tick();
    iReq = 8'hFF;
    expQ.push_back(3'd5);
    waitIrq(1'b1, ok);
    chkCnt++; if (!ok) begin errCnt++; $display("FAIL rot_wait1 got no irq expected irq"); end
    popExp(expV);
    chkCnt++; if (oVecR !== expV) begin errCnt++;
      $display("FAIL rot_first got=%0d expected %0d", oVecR, expV); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chkCnt++; if (oBusyR !== 1'b1 || oPendR !== 8'h08) begin errCnt++;
      $display("FAIL rot_ack got busy=%b pend=%h expected 1/08", oBusyR, oPendR); end
    iReq = 8'hDF;
    tick();
    iReq = 8'hFF;
    chkCnt++; if (oPendR !== 8'h28) begin errCnt++;
      $display("FAIL rot_repend got=%h expected 28", oPendR); end
    iEoi = 1'b1;
    tick();
    iEoi = 1'b0;
    expQ.push_back(3'd3);
    expQ.push_back(3'd5);
    waitIrq(1'b1, ok);
    chkCnt++; if (!ok) begin errCnt++; $display("FAIL rot_wait2 got no irq expected irq"); end
    popExp(expV);
    chkCnt++; if (oVecR !== expV) begin errCnt++;
      $display("FAIL rot_second got=%0d expected %0d", oVecR, expV); end
    iAck = 1'b1; tick(); iAck = 1'b0;
    iEoi = 1'b1; tick(); iEoi = 1'b0;
    waitIrq(1'b1, ok);
    chkCnt++; if (!ok) begin errCnt++; $display("FAIL rot_wait3 got no irq expected irq"); end
    popExp(expV);
    chkCnt++; if (oVecR !== expV) begin errCnt++;
      $display("FAIL rot_third got=%0d expected %0d", oVecR, expV); end
  endtask

  task automatic test_mask();
    doReset();
    iMask = 8'h10;
    iReq = 8'hEF;
    tick();
    iReq = 8'hFF;
    repeat (2) tick();
    chkCnt++; if (oIrq !== 1'b0 || oEO !== 1'b1 || oPend !== 8'h10) begin errCnt++;
      $display("FAIL mask_hold got irq=%b eo=%b pend=%h expected 0/1/10", oIrq, oEO, oPend); end
    iMask = 8'h00;
    #1;
    chkCnt++; if (oEO !== 1'b0) begin errCnt++;
      $display("FAIL mask_eo_comb got=%b expected 0", oEO); end
    expQ.push_back(3'd4);
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV) begin errCnt++;
      $display("FAIL unmask_grant got irq=%b vec=%0d expected 1/%0d", oIrq, oVec, expV); end
  endtask

  task automatic test_ei();
    doReset();
    iReq = 8'hF7;
    tick();
    iReq = 8'hFF;
    expQ.push_back(3'd3);
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV) begin errCnt++;
      $display("FAIL ei_first got irq=%b vec=%0d expected 1/%0d", oIrq, oVec, expV); end
    iEI = 1'b1;
    tick();
    chkCnt++; if (oIrq !== 1'b0 || oPend !== 8'h08 || oEO !== 1'b0) begin errCnt++;
      $display("FAIL ei_drop got irq=%b pend=%h eo=%b expected 0/08/0", oIrq, oPend, oEO); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chkCnt++; if (oBusy !== 1'b0 || oPend !== 8'h08 || oIrq !== 1'b0) begin errCnt++;
      $display("FAIL stray_ack got busy=%b pend=%h irq=%b expected 0/08/0", oBusy, oPend, oIrq); end
    iEI = 1'b0;
    expQ.push_back(3'd3);
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV) begin errCnt++;
      $display("FAIL ei_regrant got irq=%b vec=%0d expected 1/%0d", oIrq, oVec, expV); end
  endtask

  task automatic test_ack_collide_and_async_reset();
    doReset();
    iReq = 8'hFD;
    tick();
    iReq = 8'hFF;
    expQ.push_back(3'd1);
    tick();
    popExp(expV);
    chkCnt++; if (oIrq !== 1'b1 || oVec !== expV) begin errCnt++;
      $display("FAIL coll_grant got irq=%b vec=%0d expected 1/%0d", oIrq, oVec, expV); end
    iAck = 1'b1;
    iReq = 8'hFD;
    tick();
    iAck = 1'b0;
    iReq = 8'hFF;
    chkCnt++; if (oBusy !== 1'b1 || oPend !== 8'h02 || oVec !== 3'd1) begin errCnt++;
      $display("FAIL set_wins got busy=%b pend=%h vec=%0d expected 1/02/1", oBusy, oPend, oVec); end
    #2;
    iRst = 1'b1;
    #1;
    chkCnt++; if ({oIrq, oVec, oBusy, oPend} !== 13'h0) begin errCnt++;
      $display("FAIL async_rst got irq=%b vec=%0d busy=%b pend=%h expected all 0", oIrq, oVec, oBusy, oPend); end
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_rotate();
    test_mask();
    test_ei();
    test_ack_collide_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
